// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and
// counter sizing helper.
package sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // clog2(n) with a floor of one bit so a single-slice build still has a counter
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((2 ** w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Request/result bundle between a client and the serial subtractor.
interface serial_sub_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dif;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, dif, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, dif, bout, ovf
  );

endinterface

// File: rtl/sub_slice.sv
// Combinational B-bit ripple-borrow subtractor slice (x - y - br_in).
module sub_slice
  import sub_pkg::*;
#(
  parameter int B = 1
) (
  input  logic [B-1:0] x,
  input  logic [B-1:0] y,
  input  logic         br_in,
  output logic [B-1:0] d,
  output logic         br_out
);

  logic [B:0] br_s;

  assign br_s[0] = br_in;

  for (genvar i = 0; i < B; i++) begin : g_bit
    assign d[i]      = x[i] ^ y[i] ^ br_s[i];
    assign br_s[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br_s[i]);
  end

  assign br_out = br_s[B];

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: dif = a - b - bin, BITS_PER_CYC bits per clock,
// LSB slice first, with start/done handshake and signed-overflow flag.
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int BITS_PER_CYC = 1
) (
  input logic        clk,
  input logic        rst,
  serial_sub_if.slave bus
);

  localparam int N     = WIDTH / BITS_PER_CYC;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_sub: WIDTH must be at least 2");
  end
  if ((BITS_PER_CYC < 1) || ((WIDTH % BITS_PER_CYC) != 0)) begin : g_bad_slice
    $error("serial_sub: BITS_PER_CYC must divide WIDTH");
  end

  state_t                 state_r;
  state_t                 state_nx_s;
  logic                   accept_s;
  logic                   last_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [WIDTH-1:0]       a_sh_r;
  logic [WIDTH-1:0]       b_sh_r;
  logic                   a_msb_r;
  logic                   b_msb_r;
  logic                   br_r;
  logic [WIDTH-1:0]       dif_r;
  logic                   bout_r;
  logic                   ovf_r;
  logic                   busy_r;
  logic                   done_r;
  logic [BITS_PER_CYC-1:0] d_s;
  logic                   br_s;

  // Operands shift right each cycle so the active slice is always the low bits
  sub_slice #(
    .B(BITS_PER_CYC)
  ) u_slice (
    .x     (a_sh_r[BITS_PER_CYC-1:0]),
    .y     (b_sh_r[BITS_PER_CYC-1:0]),
    .br_in (br_r),
    .d     (d_s),
    .br_out(br_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode plus accept/last-slice strobes
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nx_s = RUN;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST) begin
          state_nx_s = IDLE;
          last_s     = 1'b1;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Operand latch, slice datapath and registered result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      br_r    <= 1'b0;
      dif_r   <= {WIDTH{1'b0}};
      bout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == RUN);
      done_r <= last_s;
      if (accept_s) begin
        cnt_r   <= {CNT_W{1'b0}};
        a_sh_r  <= bus.a;
        b_sh_r  <= bus.b;
        a_msb_r <= bus.a[WIDTH-1];
        b_msb_r <= bus.b[WIDTH-1];
        br_r    <= bus.bin;
      end else if (state_r == RUN) begin
        cnt_r  <= cnt_r + ONE;
        a_sh_r <= a_sh_r >> BITS_PER_CYC;
        b_sh_r <= b_sh_r >> BITS_PER_CYC;
        br_r   <= br_s;
        dif_r[cnt_r*BITS_PER_CYC +: BITS_PER_CYC] <= d_s;
        // The top slice carries the result MSB, so overflow is decided here
        if (last_s) begin
          bout_r <= br_s;
          ovf_r  <= (a_msb_r ^ b_msb_r) & (d_s[BITS_PER_CYC-1] ^ a_msb_r);
        end
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.dif  = dif_r;
  assign bus.bout = bout_r;
  assign bus.ovf  = ovf_r;

endmodule
